axis_bram_frame_arbiter: RTL and testbench
==========================================

# axis_bram_frame_arbiter

Frame-granular arbiter and ring-buffer controller that shares one single-port BRAM between the AXI-Stream ingress writer path and the downstream frame reader. It owns the write/read pointers, tracks occupancy and complete-frame count, grants whole frames to one side at a time, and drops ingress frames that would overflow. It sits between `axis_write_module`'s word stream and the BRAM, with the reader on the other port.

## Interface
Parameters:
- `data_width`, 512, BRAM word and stream data width
- `counter_width`, 4, address width; buffer depth `DEPTH = 2**counter_width` words (16)

Ports:
- `axis_clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-low reset (sampled on `axis_clk`)
- `wr_req`  in  1  writer has a word
- `wr_data`  in  data_width  writer word
- `wr_last`  in  1  word ends the writer's frame
- `wr_grant`  out  1  word accepted this cycle (written or discarded)
- `wr_drop`  out  1  one-cycle pulse: current ingress frame dropped
- `rd_req`  in  1  reader wants next word
- `rd_grant`  out  1  read issued this cycle
- `rd_valid`  out  1  `rd_data` valid (one cycle after `rd_grant`)
- `rd_data`  out  data_width  equals `bram_dout` when `rd_valid`
- `rd_last`  out  1  qualifies `rd_data` as last word of frame
- `bram_ena`  out  1  BRAM enable
- `bram_wena`  out  1  BRAM write enable, `[0:0]`
- `bram_address`  out  counter_width  BRAM address
- `bram_data`  out  data_width  BRAM write data
- `bram_dout`  in  data_width  BRAM read data, 1-cycle latency
- `level`  out  counter_width+1  committed + in-progress words stored, 0..DEPTH
- `frame_count`  out  counter_width+1  complete frames stored
- `full`, `empty`  out  1 each  `level==DEPTH`, `level==0`

## Operation
- States: `IDLE`, `WR_FRAME`, `WR_DROP`, `RD_FRAME`.
- IDLE: no grants. Write eligible = `wr_req && !full`; read eligible = `rd_req && frame_count!=0`. One eligible → go to its state. Both → round-robin: pick side not recorded in `last_owner`; `last_owner` updated on entry. Reset value of `last_owner` = read, so write wins first conflict.
- WR_FRAME: `wr_grant = wr_req && !full`; on grant write `wr_data` at `wptr`, store `wr_last` in per-slot last-flag array, `wptr++` (wraps mod DEPTH), `level++`. Granted `wr_last` → `frame_count++`, `frame_start <= wptr+1`, → IDLE.
- Overflow: in WR_FRAME with `wr_req && full` → `wr_drop` pulse, `wptr <= frame_start`, `level -= words written this frame`, → WR_DROP (same edge).
- WR_DROP: `wr_grant = wr_req`, no BRAM access; granted `wr_last` → IDLE. If the overflowing word itself carries `wr_last`, drop completes in that cycle and state → IDLE.
- RD_FRAME: `rd_grant = rd_req` (frame fully present, never empty); read at `rptr`, `rptr++`, `level--`. Granted word whose last flag is set → `frame_count--`, → IDLE.
- Requester deasserting `*_req` mid-frame stalls; state held indefinitely.
- Frames longer than DEPTH are always dropped.

## Timing
- Reset (`reset==0` at edge): state IDLE, pointers/`frame_start`/`level`/`frame_count` 0, `last_owner`=read; all outputs 0 except `empty`=1. Mid-operation reset discards all contents; `rd_valid` 0 the following cycle.
- One bubble cycle in IDLE between frames; back-to-back words within a frame at full rate.
- BRAM outputs combinational from grant: `bram_ena = wr_grant&&state==WR_FRAME || rd_grant`; `bram_wena` = write; `bram_address` = `wptr` or `rptr`; `bram_data = wr_data`.
- `rd_valid`, `rd_last` registered from `rd_grant` and last flag: latency 1.
- `level`/`frame_count`/`full`/`empty` update at the granting edge; never simultaneous inc/dec (exclusive sides).

## Structure
- Package `axis_buf_pkg`: state enum, `last_owner` encoding, `DEPTH` derivation.
- Sub-module `frame_last_flags`: DEPTH×1 register array, write port at `wptr`, registered read at `rptr`.

## Test plan
- Reset, then 3-word write frame (A,B,C, last on C) → addresses 0,1,2 written, `frame_count`=1, `level`=3.
- Then read 3 words → `rd_data` A,B,C at grant+1, `rd_last` only with C, `empty`=1.
- Both request in IDLE with 1 stored frame, twice → first write, then read (round-robin).
- 20-word write frame into empty buffer → `wr_drop` on word 17, words 17–20 granted, `level`=0, `wptr`=0.
- Write frames until `wptr` wraps from 15 to 0 with interleaved reads → data order preserved, `level` tracks exactly.
- `reset` low mid-RD_FRAME → next cycle all counters 0, `rd_valid`=0, `empty`=1.

Source files
------------

// File: rtl/axis_buf_pkg.sv
// Shared types for the BRAM frame arbiter: FSM states, ownership encoding
// and buffer depth derivation.
package axis_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_FRAME = 2'd1,
    ST_WR_DROP  = 2'd2,
    ST_RD_FRAME = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_RD = 1'b0,
    OWNER_WR = 1'b1
  } owner_e;

  function automatic int unsigned buf_depth(input int unsigned cw);
    return 32'd1 << cw;
  endfunction

endpackage

// File: rtl/frame_last_flags.sv
// Per-slot end-of-frame flags for the ring buffer; the combinational peek lets
// the arbiter end a read frame on the granting edge.
module frame_last_flags
  import axis_buf_pkg::*;
#(
  parameter int unsigned counter_width = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     wr_en_i,
  input  logic [counter_width-1:0] wr_addr_i,
  input  logic                     wr_flag_i,
  input  logic                     rd_en_i,
  input  logic [counter_width-1:0] rd_addr_i,
  output logic                     rd_peek_o,
  output logic                     rd_flag_o
);

  localparam int unsigned DEPTH = buf_depth(counter_width);

  logic flags_q [DEPTH];
  logic rd_flag_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      flags_q[wr_addr_i] <= wr_flag_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      rd_flag_q <= 1'b0;
    end else begin
      rd_flag_q <= rd_en_i ? flags_q[rd_addr_i] : 1'b0;
    end
  end

  assign rd_peek_o = flags_q[rd_addr_i];
  assign rd_flag_o = rd_flag_q;

endmodule

// File: rtl/axis_bram_frame_arbiter.sv
// Frame-granular arbiter sharing one single-port BRAM ring buffer between the
// ingress writer and the frame reader; overflowing ingress frames are dropped.
module axis_bram_frame_arbiter
  import axis_buf_pkg::*;
#(
  parameter int unsigned data_width    = 512,
  parameter int unsigned counter_width = 4
) (
  input  logic                     axis_clk,
  input  logic                     reset,
  input  logic                     wr_req,
  input  logic [data_width-1:0]    wr_data,
  input  logic                     wr_last,
  output logic                     wr_grant,
  output logic                     wr_drop,
  input  logic                     rd_req,
  output logic                     rd_grant,
  output logic                     rd_valid,
  output logic [data_width-1:0]    rd_data,
  output logic                     rd_last,
  output logic                     bram_ena,
  output logic                     bram_wena,
  output logic [counter_width-1:0] bram_address,
  output logic [data_width-1:0]    bram_data,
  input  logic [data_width-1:0]    bram_dout,
  output logic [counter_width:0]   level,
  output logic [counter_width:0]   frame_count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned DEPTH = buf_depth(counter_width);
  localparam logic [counter_width:0] DEPTH_L = (counter_width+1)'(DEPTH);

  arb_state_e               state_q, state_d;
  owner_e                   owner_q, owner_d;
  logic [counter_width-1:0] wptr_q, wptr_d;
  logic [counter_width-1:0] rptr_q, rptr_d;
  logic [counter_width-1:0] fstart_q, fstart_d;
  logic [counter_width:0]   level_q, level_d;
  logic [counter_width:0]   fcount_q, fcount_d;
  logic [counter_width:0]   fwords_q, fwords_d;
  logic                     rd_valid_q;
  logic                     wr_we;
  logic                     wr_elig;
  logic                     rd_elig;
  logic                     last_peek;

  assign full  = (level_q == DEPTH_L);
  assign empty = (level_q == '0);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    fstart_d = fstart_q;
    level_d  = level_q;
    fcount_d = fcount_q;
    fwords_d = fwords_q;
    wr_grant = 1'b0;
    wr_drop  = 1'b0;
    rd_grant = 1'b0;
    wr_we    = 1'b0;
    wr_elig  = wr_req && !full;
    rd_elig  = rd_req && (fcount_q != '0);

    unique case (state_q)
      ST_IDLE: begin
        if (wr_elig && (!rd_elig || owner_q == OWNER_RD)) begin
          state_d  = ST_WR_FRAME;
          owner_d  = OWNER_WR;
          fwords_d = '0;
        end else if (rd_elig) begin
          state_d = ST_RD_FRAME;
          owner_d = OWNER_RD;
        end
      end
      ST_WR_FRAME: begin
        // The overflowing word is accepted (discarded) but never reaches the BRAM.
        if (wr_req) begin
          wr_grant = 1'b1;
          if (!full) begin
            wr_we    = 1'b1;
            wptr_d   = wptr_q + 1'b1;
            level_d  = level_q + 1'b1;
            fwords_d = fwords_q + 1'b1;
            if (wr_last) begin
              fcount_d = fcount_q + 1'b1;
              fstart_d = wptr_q + 1'b1;
              state_d  = ST_IDLE;
            end
          end else begin
            wr_drop = 1'b1;
            wptr_d  = fstart_q;
            level_d = level_q - fwords_q;
            state_d = wr_last ? ST_IDLE : ST_WR_DROP;
          end
        end
      end
      ST_WR_DROP: begin
        wr_grant = wr_req;
        if (wr_req && wr_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_FRAME: begin
        if (rd_req) begin
          rd_grant = 1'b1;
          rptr_d   = rptr_q + 1'b1;
          level_d  = level_q - 1'b1;
          if (last_peek) begin
            fcount_d = fcount_q - 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWNER_RD;
      wptr_q     <= '0;
      rptr_q     <= '0;
      fstart_q   <= '0;
      level_q    <= '0;
      fcount_q   <= '0;
      fwords_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      fstart_q   <= fstart_d;
      level_q    <= level_d;
      fcount_q   <= fcount_d;
      fwords_q   <= fwords_d;
      rd_valid_q <= rd_grant;
    end
  end

  frame_last_flags #(
    .counter_width(counter_width)
  ) u_flags (
    .clk_i    (axis_clk),
    .reset_i  (reset),
    .wr_en_i  (wr_we),
    .wr_addr_i(wptr_q),
    .wr_flag_i(wr_last),
    .rd_en_i  (rd_grant),
    .rd_addr_i(rptr_q),
    .rd_peek_o(last_peek),
    .rd_flag_o(rd_last)
  );

  assign bram_ena     = wr_we || rd_grant;
  assign bram_wena    = wr_we;
  assign bram_address = wr_we ? wptr_q : (rd_grant ? rptr_q : '0);
  assign bram_data    = wr_we ? wr_data : '0;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_valid_q ? bram_dout : '0;
  assign level        = level_q;
  assign frame_count  = fcount_q;

endmodule

// File: tb/tb_axis_bram_frame_arbiter.sv
// Directed bench for the BRAM frame arbiter with a behavioural 1-cycle BRAM.
module tb_axis_bram_frame_arbiter;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          axis_clk = 1'b0;
  logic          reset;
  logic          wr_req, wr_last, wr_grant, wr_drop;
  logic [DW-1:0] wr_data;
  logic          rd_req, rd_grant, rd_valid, rd_last;
  logic [DW-1:0] rd_data;
  logic          bram_ena, bram_wena;
  logic [CW-1:0] bram_address;
  logic [DW-1:0] bram_data, bram_dout;
  logic [CW:0]   level, frame_count;
  logic          full, empty;

  logic [DW-1:0] mem [16];

  int errors = 0;
  int checks = 0;

  always #5 axis_clk = ~axis_clk;

  always @(posedge axis_clk) begin
    if (bram_ena && bram_wena) mem[bram_address] <= bram_data;
    if (bram_ena && !bram_wena) bram_dout <= mem[bram_address];
  end

  axis_bram_frame_arbiter #(
    .data_width   (DW),
    .counter_width(CW)
  ) dut (
    .axis_clk    (axis_clk),
    .reset       (reset),
    .wr_req      (wr_req),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .wr_grant    (wr_grant),
    .wr_drop     (wr_drop),
    .rd_req      (rd_req),
    .rd_grant    (rd_grant),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .bram_ena    (bram_ena),
    .bram_wena   (bram_wena),
    .bram_address(bram_address),
    .bram_data   (bram_data),
    .bram_dout   (bram_dout),
    .level       (level),
    .frame_count (frame_count),
    .full        (full),
    .empty       (empty)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge axis_clk);
    @(negedge axis_clk);
  endtask

  task automatic wr_frame(input int n, input logic [31:0] base, input int start);
    wr_req = 1'b1; wr_data = base; wr_last = (n == 1);
    #1 check("wr_idle_nogrant", 64'(wr_grant), 64'd0);
    tick();
    for (int i = 0; i < n; i++) begin
      wr_data = base + 32'(i);
      wr_last = (i == n - 1);
      #1;
      check("wr_grant", 64'(wr_grant), 64'd1);
      check("wr_wena", 64'(bram_wena), 64'd1);
      check("wr_addr", 64'(bram_address), 64'((start + i) % 16));
      tick();
    end
    wr_req = 1'b0; wr_last = 1'b0;
  endtask

  task automatic rd_frame(input int n, input logic [31:0] base, input int start);
    rd_req = 1'b1;
    #1 check("rd_idle_nogrant", 64'(rd_grant), 64'd0);
    tick();
    for (int i = 0; i < n; i++) begin
      #1;
      check("rd_grant", 64'(rd_grant), 64'd1);
      check("rd_addr", 64'(bram_address), 64'((start + i) % 16));
      tick();
      if (i == n - 1) rd_req = 1'b0;
      #1;
      check("rd_valid", 64'(rd_valid), 64'd1);
      check("rd_data", 64'(rd_data), 64'(base + 32'(i)));
      check("rd_last", 64'(rd_last), 64'(i == n - 1));
    end
  endtask

  task automatic check_counts(input string tag, input int lv, input int fc);
    check({tag, "_level"}, 64'(level), 64'(lv));
    check({tag, "_fcount"}, 64'(frame_count), 64'(fc));
    check({tag, "_empty"}, 64'(empty), 64'(lv == 0));
    check({tag, "_full"}, 64'(full), 64'(lv == 16));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; wr_req = 1'b0; wr_last = 1'b0; wr_data = '0; rd_req = 1'b0;
    tick(); tick();
    #1;
    check_counts("reset", 0, 0);
    check("reset_rd_valid", 64'(rd_valid), 64'd0);
    check("reset_bram_ena", 64'(bram_ena), 64'd0);
    check("reset_bram_addr", 64'(bram_address), 64'd0);
    check("reset_rd_data", 64'(rd_data), 64'd0);
    reset = 1'b1;
    tick();

    // Basic 3-word frame in and out.
    wr_frame(3, 32'hA0, 0);
    #1 check_counts("w3", 3, 1);
    rd_frame(3, 32'hA0, 0);
    #1 check_counts("r3", 0, 0);

    // Round-robin setup: leave one frame stored with last owner = read.
    wr_frame(2, 32'hB0, 3);
    wr_frame(1, 32'hC0, 5);
    #1 check_counts("w21", 3, 2);
    rd_frame(2, 32'hB0, 3);
    #1 check_counts("rb", 1, 1);

    wr_req = 1'b1; rd_req = 1'b1; wr_data = 32'hD0; wr_last = 1'b1;
    tick();
    #1;
    check("rr_first_wr", 64'(wr_grant), 64'd1);
    check("rr_first_nord", 64'(rd_grant), 64'd0);
    check("rr_first_addr", 64'(bram_address), 64'd6);
    tick();
    wr_data = 32'hE0;
    #1 check_counts("rr_mid", 2, 2);
    tick();
    #1;
    check("rr_second_rd", 64'(rd_grant), 64'd1);
    check("rr_second_nowr", 64'(wr_grant), 64'd0);
    check("rr_second_addr", 64'(bram_address), 64'd5);
    wr_req = 1'b0; wr_last = 1'b0;
    tick();
    rd_req = 1'b0;
    #1;
    check("rr_rd_data", 64'(rd_data), 64'hC0);
    check("rr_rd_last", 64'(rd_last), 64'd1);
    rd_frame(1, 32'hD0, 6);
    #1 check_counts("rr_done", 0, 0);

    // Pointer wrap with interleaved reads (wptr = rptr = 7 here).
    wr_frame(5, 32'h100, 7);
    #1 check_counts("wrap_a", 5, 1);
    rd_frame(5, 32'h100, 7);
    wr_frame(6, 32'h200, 12);
    #1 check_counts("wrap_b", 6, 1);
    wr_frame(3, 32'h300, 2);
    #1 check_counts("wrap_c", 9, 2);
    rd_frame(6, 32'h200, 12);
    #1 check_counts("wrap_d", 3, 1);
    rd_frame(3, 32'h300, 2);
    #1 check_counts("wrap_e", 0, 0);

    // 20-word frame into an empty, freshly reset buffer is dropped at word 17.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    wr_req = 1'b1; wr_data = 32'h400; wr_last = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      wr_data = 32'h400 + 32'(i);
      wr_last = (i == 19);
      #1;
      check("drop_grant", 64'(wr_grant), 64'd1);
      check("drop_pulse", 64'(wr_drop), 64'(i == 16));
      check("drop_ena", 64'(bram_ena), 64'(i < 16));
      if (i == 16) check("drop_full", 64'(full), 64'd1);
      tick();
    end
    wr_req = 1'b0; wr_last = 1'b0;
    #1 check_counts("dropped", 0, 0);
    wr_frame(2, 32'h500, 0);
    #1 check_counts("after_drop", 2, 1);
    rd_frame(2, 32'h500, 0);

    // Reset in the middle of a read frame.
    wr_frame(4, 32'h600, 2);
    rd_req = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1; rd_req = 1'b0;
    #1;
    check_counts("mid_reset", 0, 0);
    check("mid_reset_rd_valid", 64'(rd_valid), 64'd0);
    check("mid_reset_rd_last", 64'(rd_last), 64'd0);
    check("mid_reset_rd_data", 64'(rd_data), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
